// File: rtl/data_memory_be.sv
// Byte-enabled 32-bit data memory with zero-latency loads, alignment/range checks
// and an optional post-reset sweep that clears every word.
module data_memory_be #(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_busy;
    logic [31:0]     r_mem [DEPTH];

    logic [AW-1:0]   w_idx;
    logic [1:0]      w_lane;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_store;
    logic            w_clear;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_idx  = address[AW+1:2];
    assign w_lane = address[1:0];

    always_comb begin
        w_misaligned = 1'b0;
        case (size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = address[0];
            default: w_misaligned = (address[1:0] != 2'b00);
        endcase
    end

    assign w_out_of_range = ({2'b00, address[31:2]} >= 32'(DEPTH));

    // Stores and sweep writes only happen on edges where reset is released.
    assign w_store = reset & mem_write & ~r_busy & ~w_misaligned & ~w_out_of_range;
    assign w_clear = reset & (r_state == ST_CLEAR);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = write_data;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_be    = address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_RESET;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_clr_idx <= '0;
                    if (CLEAR_ON_RESET) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_idx == AW'(DEPTH - 1)) begin
                        r_state   <= ST_READY;
                        r_busy    <= 1'b0;
                        r_clr_idx <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + AW'(1);
                    end
                end
                ST_READY: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= ST_RESET;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_store) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // Loads read the pre-edge array contents, so a same-cycle store is seen next cycle.
    always_comb begin
        w_word = r_mem[w_idx];
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = address[1] ? w_word[31:16] : w_word[15:0];
    end

    always_comb begin
        read_data = '0;
        if (!r_busy && !w_misaligned && !w_out_of_range) begin
            case (size)
                2'b00:   read_data = {{24{~load_unsigned & w_byte[7]}}, w_byte};
                2'b01:   read_data = {{16{~load_unsigned & w_half[15]}}, w_half};
                default: read_data = w_word;
            endcase
        end
    end

    assign misaligned   = w_misaligned;
    assign out_of_range = w_out_of_range;
    assign busy         = r_busy;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/data_memory_be.md
DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words; power of two, minimum 4.
REQ-002 Parameter CLEAR_ON_RESET, default 1: 1 = sweep-clear all words after reset; 0 = no clear.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
REQ-005 Port address, input, 32: byte address.
REQ-006 Port write_data, input, 32: store data, right-aligned (bits [7:0] for a byte, [15:0] for a half).
REQ-007 Port mem_write, input, 1: store request this cycle.
REQ-008 Port size, input, 2: access size; 00 byte, 01 half, 10 word, 11 reserved and treated as word.
REQ-009 Port load_unsigned, input, 1: 1 = zero-extend loads; 0 = sign-extend loads.
REQ-010 Port read_data, output, 32: combinational load result.
REQ-011 Port misaligned, output, 1: combinational; current access violates alignment.
REQ-012 Port out_of_range, output, 1: combinational; address[31:2] >= DEPTH.
REQ-013 Port busy, output, 1: registered; memory is in reset or clear sweep.

Function
REQ-014 Word index SHALL be address[31:2]; byte lane SHALL be address[1:0]; little-endian, lane 0 = bits [7:0].
REQ-015 Misalignment rules: half with address[0]=1 is misaligned; word with address[1:0]!=00 is misaligned; byte accesses are never misaligned.
REQ-016 Store SHALL commit at the rising clk edge only when mem_write=1, busy=0, misaligned=0 and out_of_range=0; otherwise it is dropped with no side effect.
REQ-017 Byte store SHALL update only lane address[1:0]; half store SHALL update lanes {address[1],0} and {address[1],1}; word store SHALL update all 4 lanes; untouched lanes SHALL be preserved.
REQ-018 read_data SHALL be derived combinationally from the addressed word; there is no read enable and zero read latency.
REQ-019 Byte load SHALL return the selected lane extended to 32 bits; half load SHALL return the selected half-word extended to 32 bits; extension SHALL follow load_unsigned.
REQ-020 read_data SHALL be 0 when busy=1, misaligned=1 or out_of_range=1.
REQ-021 Read and write to the same word in one cycle SHALL return the old contents; the new value SHALL be visible from the next cycle.
REQ-022 FSM states SHALL be RESET, CLEAR and READY.
REQ-023 While reset=0 the FSM SHALL be in RESET; on the first edge with reset=1 it SHALL go to CLEAR if CLEAR_ON_RESET=1, else to READY.
REQ-024 CLEAR SHALL write 0 to word clr_idx each cycle, with clr_idx counting 0..DEPTH-1 ($clog2(DEPTH) bits); after writing DEPTH-1 the FSM SHALL go to READY, so the sweep lasts exactly DEPTH cycles.
REQ-025 busy SHALL be 1 in RESET and CLEAR and 0 in READY.
REQ-026 Reset asserted during CLEAR SHALL abort the sweep and return to RESET; the next sweep SHALL restart at index 0.
REQ-027 With CLEAR_ON_RESET=0, memory contents SHALL be retained across reset; no array write occurs in RESET.
REQ-028 misaligned and out_of_range SHALL be reported for reads and writes alike, independent of busy.

Reset
REQ-029 While reset=0: busy=1, read_data=0, FSM=RESET, clr_idx=0; stores are ignored.
REQ-030 After a completed sweep (CLEAR_ON_RESET=1), every word SHALL read 0.

Verification
REQ-031 Hold reset=0 for 3 cycles, then release with DEPTH=16 -> busy=1 for exactly 16 further cycles, then 0; afterwards all 16 words read 0.
REQ-032 Word store 0x11223344 @0x8, then byte store 0xAA @0x9 -> word load @0x8 = 0x1122AA44; signed byte load @0x9 = 0xFFFFFFAA; unsigned byte load @0x9 = 0x000000AA.
REQ-033 Half store 0x8001 @0x6 -> signed half load @0x6 = 0xFFFF8001; unsigned half load @0x6 = 0x00008001; word load @0x4 shows 0x8001 in bits [31:16].
REQ-034 Word store @0x5 and half store @0x3 -> misaligned=1, memory unchanged, read_data=0.
REQ-035 DEPTH=16, store @0x40 -> out_of_range=1, no write, read_data=0; word 0 unchanged.
REQ-036 Assert reset=0 at clear cycle 5, then release -> the sweep restarts and busy lasts a full DEPTH cycles; a store issued during busy is dropped.
